kyber_enc_input_loader: RTL and testbench

- Upstream feeder for kyber_pke_enc.
- Watches the core's input_type request, takes a typed byte stream from the host over a valid/ready handshake, and drives the core's readin/full_in/data_type/kyber_din/kyber_in_index interface.
- Replaces ad-hoc sequencing at the core boundary with an FSM that owns per-type byte counts, index generation and end-of-segment signalling.

---
 rtl/kyber_enc_input_loader.sv | 177 +++++++++++++++++
 tb/tb_kyber_enc_input_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kyber_enc_input_loader.sv
// kyber_enc_input_loader
//
// Upstream feeder for kyber_pke_enc. Watches the core's input_type request,
// pulls the matching typed byte segment from the host over a valid/ready
// handshake, and presents it to the core as readin strobes with a per-segment
// byte index. A single-cycle full_in pulse follows the final byte.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   host_din/valid    host byte stream; host_last marks the final byte
//   host_ready        combinational: loader is loading and the core can take a byte
//   host_req_type     segment type the host must send (0 = none)
//   core_input_type   type requested by the core (1=r, 2=t-hat, 3=m, 4=rho)
//   core_readin_ok    core can accept a byte
//   core_readin       one-cycle byte strobe to the core
//   core_full_in      one-cycle segment-complete pulse
//   core_data_type    type tag of the current segment (0 only in IDLE)
//   core_din          byte to the core
//   core_in_index     byte index within the segment
//   busy              FSM not in IDLE
//   err               sticky protocol error
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a valid core_input_type request
// LOAD  | accepting host bytes and strobing them into the core
// FULL  | all bytes delivered; full_in is issued from this state
// WAIT  | segment done; wait for the core to move off this type

module kyber_enc_input_loader #(
   parameter int K         = 3,
   parameter int R_BYTES   = 32,
   parameter int M_BYTES   = 32,
   parameter int RHO_BYTES = 32,
   parameter int T_BYTES   = 384 * K
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  host_din,
   input  logic        host_valid,
   input  logic        host_last,
   output logic        host_ready,
   output logic [3:0]  host_req_type,
   input  logic [3:0]  core_input_type,
   input  logic        core_readin_ok,
   output logic        core_readin,
   output logic        core_full_in,
   output logic [3:0]  core_data_type,
   output logic [7:0]  core_din,
   output logic [15:0] core_in_index,
   output logic        busy,
   output logic        err
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL, S_WAIT} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cur_type, cur_type_nxt;
   logic [15:0] len, len_nxt;
   logic [15:0] cnt, cnt_nxt;
   logic        accept;
   logic        last_byte;

   logic        readin_d;
   logic        full_in_d;
   logic [3:0]  data_type_d;
   logic [7:0]  din_d;
   logic [15:0] index_d;
   logic        busy_d;
   logic        err_d;
   logic [3:0]  req_type_d;

   function automatic logic [15:0] seg_len(input logic [3:0] t);
      logic [15:0] l;
      l = 16'd0;
      case (t)
         4'd1:    l = 16'(R_BYTES);
         4'd2:    l = 16'(T_BYTES);
         4'd3:    l = 16'(M_BYTES);
         4'd4:    l = 16'(RHO_BYTES);
         default: l = 16'd0;
      endcase
      return l;
   endfunction

   assign host_ready = (state == S_LOAD) & core_readin_ok;
   assign accept     = host_valid & host_ready;
   assign last_byte  = (cnt == len - 16'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         cur_type <= 4'd0;
         len      <= 16'd0;
         cnt      <= 16'd0;
      end else begin
         state    <= state_nxt;
         cur_type <= cur_type_nxt;
         len      <= len_nxt;
         cnt      <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cur_type_nxt = cur_type;
      len_nxt      = len;
      cnt_nxt      = cnt;
      case (state)
         S_IDLE: begin
            if (core_input_type >= 4'd1 && core_input_type <= 4'd4) begin
               cur_type_nxt = core_input_type;
               len_nxt      = seg_len(core_input_type);
               cnt_nxt      = 16'd0;
               state_nxt    = S_LOAD;
            end
         end
         S_LOAD: begin
            // core_input_type is deliberately ignored here: a started
            // segment always runs to completion.
            if (accept) begin
               cnt_nxt = cnt + 16'd1;
               if (last_byte)
                  state_nxt = S_FULL;
            end
         end
         S_FULL: state_nxt = S_WAIT;
         S_WAIT: begin
            if (core_input_type != cur_type)
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output values are computed one cycle ahead and registered, so tags that
   // follow the state (busy, data_type, req_type) are derived from the next state.
   always_comb begin
      readin_d    = accept;
      din_d       = accept ? host_din : core_din;
      index_d     = accept ? cnt : core_in_index;
      full_in_d   = (state == S_FULL);
      data_type_d = (state_nxt == S_IDLE) ? 4'd0 : cur_type_nxt;
      req_type_d  = (state_nxt == S_LOAD) ? cur_type_nxt : 4'd0;
      busy_d      = (state_nxt != S_IDLE);
      err_d       = err;
      if (state == S_IDLE && core_input_type > 4'd4)
         err_d = 1'b1;
      if (accept && host_last && !last_byte)
         err_d = 1'b1;
      if (accept && last_byte && !host_last)
         err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         core_readin    <= 1'b0;
         core_full_in   <= 1'b0;
         core_data_type <= 4'd0;
         core_din       <= 8'd0;
         core_in_index  <= 16'd0;
         host_req_type  <= 4'd0;
         busy           <= 1'b0;
         err            <= 1'b0;
      end else begin
         core_readin    <= readin_d;
         core_full_in   <= full_in_d;
         core_data_type <= data_type_d;
         core_din       <= din_d;
         core_in_index  <= index_d;
         host_req_type  <= req_type_d;
         busy           <= busy_d;
         err            <= err_d;
      end
   end

endmodule

// File: tb/tb_kyber_enc_input_loader.sv
module tb_kyber_enc_input_loader;

   localparam int K     = 3;
   localparam int T_LEN = 384 * K;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  host_din;
   logic        host_valid;
   logic        host_last;
   logic        host_ready;
   logic [3:0]  host_req_type;
   logic [3:0]  core_input_type;
   logic        core_readin_ok;
   logic        core_readin;
   logic        core_full_in;
   logic [3:0]  core_data_type;
   logic [7:0]  core_din;
   logic [15:0] core_in_index;
   logic        busy;
   logic        err;

   kyber_enc_input_loader #(.K(K)) dut (
      .clk             (clk),
      .reset           (reset),
      .host_din        (host_din),
      .host_valid      (host_valid),
      .host_last       (host_last),
      .host_ready      (host_ready),
      .host_req_type   (host_req_type),
      .core_input_type (core_input_type),
      .core_readin_ok  (core_readin_ok),
      .core_readin     (core_readin),
      .core_full_in    (core_full_in),
      .core_data_type  (core_data_type),
      .core_din        (core_din),
      .core_in_index   (core_in_index),
      .busy            (busy),
      .err             (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Observed core-side traffic
   logic [7:0]  st_din[$];
   logic [15:0] st_idx[$];
   logic [3:0]  st_type[$];
   int          st_stamp[$];
   int          acc_stamp[$];
   int          full_cnt_seg = 0;
   int          full_total   = 0;
   int          full_stamp   = 0;

   always @(negedge clk) begin
      if (core_readin === 1'b1) begin
         st_din.push_back(core_din);
         st_idx.push_back(core_in_index);
         st_type.push_back(core_data_type);
         st_stamp.push_back(cyc);
      end
      if (core_full_in === 1'b1) begin
         full_cnt_seg++;
         full_total++;
         full_stamp = cyc;
      end
   end

   logic [7:0] data_q [0:T_LEN-1];
   bit         err_exp = 1'b0;
   int         n_pass   = 0;
   int         n_checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_readin"},   32'(core_readin), 0);
      check({tag, "_full_in"},  32'(core_full_in), 0);
      check({tag, "_dtype"},    32'(core_data_type), 0);
      check({tag, "_din"},      32'(core_din), 0);
      check({tag, "_index"},    32'(core_in_index), 0);
      check({tag, "_busy"},     32'(busy), 0);
      check({tag, "_err"},      32'(err), 0);
      check({tag, "_ready"},    32'(host_ready), 0);
      check({tag, "_req_type"}, 32'(host_req_type), 0);
   endtask

   task automatic fill_data(input bit ramp, input int len);
      for (int j = 0; j < len; j++)
         data_q[j] = ramp ? 8'(j + 2) : 8'($urandom_range(0, 255));
   endtask

   // Drive one segment of type t and length len, then check the core-side
   // traffic against the bytes sent: every byte exactly once, in order,
   // index 0..len-1, strobe one cycle after accept, full_in two cycles
   // after the final accept.
   task automatic run_seg(input int t, input int len, input bit toggle,
                          input int last_at, input int bp_at, input int abort_at);
      int  i;
      int  guard;
      int  n;
      bit  bp_done;
      i = 0; guard = 0; bp_done = 1'b0;
      st_din.delete(); st_idx.delete(); st_type.delete(); st_stamp.delete();
      acc_stamp.delete();
      full_cnt_seg = 0;
      @(negedge clk);
      core_input_type = 4'(t);
      core_readin_ok  = 1'b1;
      while (i < len && guard < 20000) begin
         if (abort_at >= 0 && i == abort_at) begin
            host_valid = 1'b0; host_last = 1'b0; reset = 1'b1;
            @(posedge clk); @(negedge clk); #1;
            check_zero_outputs("abort");
            check("abort_strobes", 32'(st_din.size()), 32'(abort_at));
            check("abort_full", 32'(full_cnt_seg), 0);
            reset   = 1'b0;
            err_exp = 1'b0;
            return;
         end
         if (bp_at >= 0 && i == bp_at && !bp_done) begin
            bp_done = 1'b1;
            core_readin_ok = 1'b0;
            host_valid = 1'b1; host_din = data_q[i]; host_last = 1'b0;
            for (int b = 0; b < 5; b++) begin
               #1;
               check("bp_ready", 32'(host_ready), 0);
               @(posedge clk); @(negedge clk);
            end
            #1;
            check("bp_strobes", 32'(st_din.size()), 32'(bp_at));
            check("bp_index", 32'(core_in_index), 32'(bp_at - 1));
            check("bp_busy", 32'(busy), 1);
            core_readin_ok = 1'b1;
         end
         host_valid = toggle ? ((guard % 2) == 0) : 1'b1;
         host_din   = data_q[i];
         host_last  = (i == len - 1) || (i == last_at);
         #1;
         if (host_valid && host_ready) begin
            if (i == 0) check("req_type", 32'(host_req_type), 32'(t));
            if (host_last && i != len - 1) err_exp = 1'b1;
            acc_stamp.push_back(cyc);
            i++;
         end
         @(posedge clk); @(negedge clk);
         guard++;
      end
      if (i < len) check("seg_timeout", 32'(i), 32'(len));
      host_valid = 1'b0; host_last = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("strobe_count", 32'(st_din.size()), 32'(len));
      n = (st_din.size() < acc_stamp.size()) ? st_din.size() : acc_stamp.size();
      for (int j = 0; j < n; j++) begin
         check("din",    32'(st_din[j]),   32'(data_q[j]));
         check("index",  32'(st_idx[j]),   32'(j));
         check("dtype",  32'(st_type[j]),  32'(t));
         check("strobe_lat", 32'(st_stamp[j]), 32'(acc_stamp[j] + 1));
      end
      check("full_count", 32'(full_cnt_seg), 1);
      if (acc_stamp.size() > 0)
         check("full_lat", 32'(full_stamp), 32'(acc_stamp[acc_stamp.size()-1] + 2));
      check("wait_busy",     32'(busy), 1);
      check("wait_req_type", 32'(host_req_type), 0);
      check("wait_ready",    32'(host_ready), 0);
      check("wait_dtype",    32'(core_data_type), 32'(t));
      check("wait_index",    32'(core_in_index), 32'(len - 1));
      check("seg_err",       32'(err), 32'(err_exp));
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      err_exp = 1'b0;
      #1;
   endtask

   int full_before;

   initial begin
      reset = 1'b1;
      host_din = 8'd0; host_valid = 1'b0; host_last = 1'b0;
      core_input_type = 4'd0; core_readin_ok = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_zero_outputs("reset");
      reset = 1'b0;
      @(negedge clk); #1;
      check("idle_busy", 32'(busy), 0);

      // Back-to-back 1, 2, 3, 4
      fill_data(1'b1, 32);
      run_seg(1, 32, 1'b0, -1, -1, -1);
      fill_data(1'b0, T_LEN);
      run_seg(2, T_LEN, 1'b1, -1, -1, -1);
      fill_data(1'b0, 32);
      run_seg(3, 32, 1'b0, -1, 10, -1);
      fill_data(1'b0, 32);
      run_seg(4, 32, 1'b0, 15, -1, -1);
      check("four_full", 32'(full_total), 4);

      // Back to IDLE; err stays sticky
      @(negedge clk);
      core_input_type = 4'd0;
      repeat (3) @(negedge clk);
      #1;
      check("idle_busy2", 32'(busy), 0);
      check("idle_dtype", 32'(core_data_type), 0);
      check("err_sticky", 32'(err), 32'(err_exp));

      pulse_reset();
      check("err_cleared", 32'(err), 0);

      // Invalid type request
      @(negedge clk);
      core_input_type = 4'd7;
      repeat (3) @(negedge clk);
      #1;
      check("bad_type_err",   32'(err), 1);
      check("bad_type_busy",  32'(busy), 0);
      check("bad_type_ready", 32'(host_ready), 0);
      core_input_type = 4'd0;
      pulse_reset();

      // Reset in the middle of a type-2 segment, then a full type-2 segment
      fill_data(1'b0, T_LEN);
      full_before = full_total;
      run_seg(2, T_LEN, 1'b0, -1, -1, 500);
      repeat (2) @(negedge clk);
      #1;
      check("abort_no_full", 32'(full_total), 32'(full_before));
      fill_data(1'b0, T_LEN);
      run_seg(2, T_LEN, 1'b0, -1, -1, -1);

      @(negedge clk);
      core_input_type = 4'd0;
      repeat (3) @(negedge clk);
      #1;
      check("final_busy", 32'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
